if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage plus the IF/ID pipeline register of the 5-stage MIPS core.
- Holds the PC and addresses instruction memory, which reads combinationally.
- Latches the fetched word and PC+4 into IF/ID, or a bubble when required.
- Presents the decoded fields (opcode, rs, rt, rd, shamt, funct, imm[15:0]) to the ID stage: register file, control unit and Immediate_Extender.
- Supports load-use stall, branch/jump redirect with IF/ID flush, and a fetch counter for debug.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pc_reg.sv | 39 +++
 rtl/if_id_fetch_stage.sv | 99 +++++++++
 tb/tb_if_id_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: reset values, bubble word and instruction field layout.
package mips_pkg;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned OPC_W     = 6;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned SHAMT_W   = 5;
   localparam int unsigned FUNCT_W   = 6;
   localparam int unsigned IMM_W     = 16;

   localparam int unsigned OPC_MSB   = 31;
   localparam int unsigned RS_MSB    = 25;
   localparam int unsigned RT_MSB    = 20;
   localparam int unsigned RD_MSB    = 15;
   localparam int unsigned SHAMT_MSB = 10;

   localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   // sll $0,$0,0
   localparam logic [INSTR_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/pc_reg.sv
// Program counter: async-reset register with hold enable and redirect/sequential next-PC mux.
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               redirect,
   input  logic [INSTR_W-1:0] redirect_pc,
   output logic [INSTR_W-1:0] pc,
   output logic [INSTR_W-1:0] pc_plus4_c
);

   logic [INSTR_W-1:0] pc_q;
   logic [INSTR_W-1:0] pc_d;

   // Sequential increment wraps naturally at 32 bits.
   assign pc_plus4_c = pc_q + INSTR_W'(4);

   always_comb begin
      pc_d = pc_q;
      if (en) begin
         pc_d = redirect ? redirect_pc : pc_plus4_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule : pc_reg

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register with stall, redirect/flush and fetch counter.
module if_id_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               redirect,
   input  logic [INSTR_W-1:0] redirect_pc,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] pc,
   output logic [INSTR_W-1:0] if_id_pc4,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid,
   output logic [OPC_W-1:0]   id_opcode,
   output logic [REG_W-1:0]   id_rs,
   output logic [REG_W-1:0]   id_rt,
   output logic [REG_W-1:0]   id_rd,
   output logic [SHAMT_W-1:0] id_shamt,
   output logic [FUNCT_W-1:0] id_funct,
   output logic [IMM_W-1:0]   id_imm,
   output logic [31:0]        fetch_count
);

   logic [INSTR_W-1:0] pc_plus4_c;
   logic               pc_en_c;

   logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
   logic [INSTR_W-1:0] if_id_pc4_q,   if_id_pc4_d;
   logic               if_id_valid_q, if_id_valid_d;
   logic [31:0]        fetch_count_q, fetch_count_d;

   // Redirect must move the PC even while the hazard unit is stalling.
   assign pc_en_c = ~stall | redirect;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (pc_en_c),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .pc_plus4_c  (pc_plus4_c)
   );

   assign imem_addr = pc;

   // Priority: redirect squashes (SQUASH), then stall holds (HOLD), else advance (RUN).
   always_comb begin
      if_id_instr_d = if_id_instr_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_valid_d = if_id_valid_q;
      fetch_count_d = fetch_count_q;
      if (redirect) begin
         if_id_instr_d = NOP_WORD;
         if_id_valid_d = 1'b0;
      end else if (!stall) begin
         if_id_instr_d = imem_rdata;
         if_id_pc4_d   = pc_plus4_c;
         if_id_valid_d = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_instr_q <= NOP_WORD;
         if_id_pc4_q   <= '0;
         if_id_valid_q <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         if_id_instr_q <= if_id_instr_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_valid_q <= if_id_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign if_id_instr = if_id_instr_q;
   assign if_id_pc4   = if_id_pc4_q;
   assign if_id_valid = if_id_valid_q;
   assign fetch_count = fetch_count_q;

   // ID sees the decoded fields in the same cycle IF/ID updates.
   assign id_opcode = if_id_instr_q[OPC_MSB   -: OPC_W];
   assign id_rs     = if_id_instr_q[RS_MSB    -: REG_W];
   assign id_rt     = if_id_instr_q[RT_MSB    -: REG_W];
   assign id_rd     = if_id_instr_q[RD_MSB    -: REG_W];
   assign id_shamt  = if_id_instr_q[SHAMT_MSB -: SHAMT_W];
   assign id_funct  = if_id_instr_q[FUNCT_W-1:0];
   assign id_imm    = if_id_instr_q[IMM_W-1:0];

endmodule : if_id_fetch_stage

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: address-tagged instruction memory, immediate-assertion checks.
module tb_if_id_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_shamt;
   logic [5:0]  id_funct;
   logic [15:0] id_imm;
   logic [31:0] fetch_count;

   logic        ovr_en;
   logic [31:0] ovr_addr;
   logic [31:0] ovr_data;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // Memory returns addr ^ A5A5_0000 unless one address is overridden.
   assign imem_rdata = (ovr_en && (imem_addr == ovr_addr)) ? ovr_data
                                                           : (imem_addr ^ 32'hA5A5_0000);

   if_id_fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .if_id_pc4   (if_id_pc4),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid),
      .id_opcode   (id_opcode),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_shamt    (id_shamt),
      .id_funct    (id_funct),
      .id_imm      (id_imm),
      .fetch_count (fetch_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_if_id(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
      check({tag, ".pc"},    pc,          e_pc);
      check({tag, ".addr"},  imem_addr,   e_pc);
      check({tag, ".instr"}, if_id_instr, e_instr);
      check({tag, ".pc4"},   if_id_pc4,   e_pc4);
      check({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
      check({tag, ".count"}, fetch_count, e_cnt);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0;

      // Reset held for 3 cycles
      repeat (3) step();
      check_if_id("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      rst_n = 1'b1;

      // Idle run from reset
      step();
      check_if_id("run1", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1, 32'd1);
      step();
      check_if_id("run2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1, 32'd2);

      // Stall for two cycles at pc=8
      stall = 1'b1;
      step();
      check_if_id("stall1", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1, 32'd2);
      step();
      check_if_id("stall2", 32'h8, 32'hA5A5_0004, 32'h8, 1'b1, 32'd2);
      stall = 1'b0;
      step();
      check_if_id("unstall", 32'hC, 32'hA5A5_0008, 32'hC, 1'b1, 32'd3);

      // Field slicing of lw $3,-8($2) fetched from address C
      ovr_en = 1'b1; ovr_addr = 32'hC; ovr_data = 32'h8C43_FFF8;
      step();
      ovr_en = 1'b0;
      check_if_id("lw", 32'h10, 32'h8C43_FFF8, 32'h10, 1'b1, 32'd4);
      check("lw.opcode", 32'(id_opcode), 32'h23);
      check("lw.rs",     32'(id_rs),     32'd2);
      check("lw.rt",     32'(id_rt),     32'd3);
      check("lw.rd",     32'(id_rd),     32'h1F);
      check("lw.shamt",  32'(id_shamt),  32'h1F);
      check("lw.funct",  32'(id_funct),  32'h38);
      check("lw.imm",    32'(id_imm),    32'hFFF8);

      // Redirect to 0x100: bubble then target word
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      check_if_id("redir", 32'h100, 32'h0, 32'h10, 1'b0, 32'd4);
      check("redir.opcode", 32'(id_opcode), 32'h0);
      step();
      check_if_id("redir_tgt", 32'h104, 32'hA5A5_0100, 32'h104, 1'b1, 32'd5);

      // Redirect wins over simultaneous stall
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      check_if_id("both", 32'h40, 32'h0, 32'h104, 1'b0, 32'd5);
      step();
      check_if_id("stall_bubble", 32'h40, 32'h0, 32'h104, 1'b0, 32'd5);
      stall = 1'b0;
      step();
      check_if_id("after_both", 32'h44, 32'hA5A5_0040, 32'h44, 1'b1, 32'd6);

      // Unaligned target passes through unchanged
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      check_if_id("unaligned", 32'h102, 32'h0, 32'h44, 1'b0, 32'd6);

      // Wrap-around at top of address space
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check_if_id("top", 32'hFFFF_FFFC, 32'h0, 32'h44, 1'b0, 32'd6);
      step();
      check_if_id("wrap", 32'h0, 32'h5A5A_FFFC, 32'h0, 1'b1, 32'd7);
      step();
      check_if_id("post_wrap", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1, 32'd8);

      // Asynchronous reset mid-cycle, checked before the next rising edge
      #2 rst_n = 1'b0;
      #1;
      check_if_id("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_if_id("rerun", 32'h4, 32'hA5A5_0000, 32'h4, 1'b1, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_if_id_fetch_stage
